planar_pred_4x4: RTL and testbench

Downstream consumer of the planar-mode reference-sample address generator in the intra-prediction path. Captures the top, top-right, left and bottom-left reference samples returned by the top and left sample RAMs. Computes the 4x4 HEVC planar prediction and emits it one row (four 8-bit samples) per cycle to the reconstruction adder.

---
 rtl/planar_pred_4x4_pkg.sv | 17 +
 rtl/planar_pred_4x4_row_calc.sv | 30 +++
 rtl/planar_pred_4x4.sv | 142 ++++++++++++++
 tb/tb_planar_pred_4x4.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/planar_pred_4x4_pkg.sv
// Shared types and constants for the 4x4 planar intra predictor.
// Block size, state encoding and reference-capture counter limits.
package planar_pred_4x4_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2
    } state_t;

    localparam int NT          = 4;
    localparam int LOG2NT      = 2;
    localparam int RAM_LAT_DEF = 1;

    localparam logic [LOG2NT-1:0] Y_LAST     = LOG2NT'(NT - 1);
    localparam logic [2:0]        CNT_CORNER = 3'd4;
    localparam logic [2:0]        CNT_FULL   = 3'd5;
endpackage

// File: rtl/planar_pred_4x4_row_calc.sv
// One row of the 4x4 planar prediction, purely combinational (zero latency).
// Worst-case weighted sum is 2044, so the SW-bit sum never overflows before the shift.
module planar_pred_4x4_row_calc
    import planar_pred_4x4_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic [LOG2NT-1:0]  y,
    input  logic [NT*BITS-1:0] top,
    input  logic [BITS-1:0]    left_y,
    input  logic [BITS-1:0]    tr,
    input  logic [BITS-1:0]    bl,
    output logic [NT*BITS-1:0] row
);
    localparam int SW = BITS + LOG2NT + 1;

    logic [SW-1:0] wy_top;
    logic [SW-1:0] wy_bl;

    assign wy_top = SW'(Y_LAST - y);
    assign wy_bl  = SW'(y) + SW'(1);

    for (genvar x = 0; x < NT; x++) begin : g_col
        assign row[x*BITS +: BITS] = BITS'((SW'(NT - 1 - x) * SW'(left_y)
                                          + SW'(x + 1) * SW'(tr)
                                          + wy_top * SW'(top[x*BITS +: BITS])
                                          + wy_bl * SW'(bl)
                                          + SW'(NT)) >> (LOG2NT + 1));
    end
endmodule

// File: rtl/planar_pred_4x4.sv
// Captures top/top-right/left/bottom-left references from the sample RAMs and emits the
// 4x4 planar prediction one row per cycle, rows 1..4 cycles after the bl capture; no backpressure.
module planar_pred_4x4
    import planar_pred_4x4_pkg::*;
#(
    parameter int RAM_LAT = RAM_LAT_DEF,
    parameter int BITS    = 8
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               preset_flag,
    input  logic               EN_TOP,
    input  logic               EN_LEFT,
    input  logic [BITS-1:0]    DATA_TOP,
    input  logic [BITS-1:0]    DATA_LEFT,
    output logic [NT*BITS-1:0] PRED_ROW,
    output logic [LOG2NT-1:0]  ROW_IDX,
    output logic               PRED_VALID,
    output logic               DONE,
    output logic               BUSY
);
    logic [RAM_LAT-1:0] top_tap;
    logic [RAM_LAT-1:0] left_tap;
    logic               en_top_d;
    logic               en_left_d;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        cnt_t;
    logic [2:0]        cnt_l;
    logic [2:0]        cnt_t_nxt;
    logic [2:0]        cnt_l_nxt;
    logic              cap_t;
    logic              cap_l;
    logic [LOG2NT-1:0] y;

    logic [BITS-1:0]    top_ref  [NT];
    logic [BITS-1:0]    left_ref [NT];
    logic [BITS-1:0]    tr;
    logic [BITS-1:0]    bl;
    logic [NT*BITS-1:0] top_vec;
    logic [NT*BITS-1:0] row;

    // Enable delay line lines the enables up with the RAM read data.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            top_tap  <= '0;
            left_tap <= '0;
        end else begin
            top_tap[0]  <= EN_TOP;
            left_tap[0] <= EN_LEFT;
            for (int i = 1; i < RAM_LAT; i++) begin
                top_tap[i]  <= top_tap[i-1];
                left_tap[i] <= left_tap[i-1];
            end
        end
    end

    assign en_top_d  = top_tap[RAM_LAT-1];
    assign en_left_d = left_tap[RAM_LAT-1];

    always_comb begin
        cap_t     = en_top_d && (state == LOAD) && (cnt_t != CNT_FULL);
        cap_l     = en_left_d && (state == LOAD) && (cnt_l != CNT_FULL);
        cnt_t_nxt = cap_t ? cnt_t + 3'd1 : cnt_t;
        cnt_l_nxt = cap_l ? cnt_l + 3'd1 : cnt_l;
        state_nxt = state;
        if (preset_flag) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                LOAD:    if (cnt_t_nxt == CNT_FULL && cnt_l_nxt == CNT_FULL) state_nxt = CALC;
                CALC:    if (y == Y_LAST) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
            cnt_t <= '0;
            cnt_l <= '0;
            y     <= '0;
        end else begin
            state <= state_nxt;
            cnt_t <= preset_flag ? 3'd0 : cnt_t_nxt;
            cnt_l <= preset_flag ? 3'd0 : cnt_l_nxt;
            y     <= (preset_flag || state != CALC) ? '0 : y + LOG2NT'(1);
        end
    end

    // Reference samples are simply overwritten by the next block's captures.
    always_ff @(posedge CLK) begin
        if (cap_t && !preset_flag) begin
            if (cnt_t == CNT_CORNER) tr <= DATA_TOP;
            else                     top_ref[cnt_t[LOG2NT-1:0]] <= DATA_TOP;
        end
        if (cap_l && !preset_flag) begin
            if (cnt_l == CNT_CORNER) bl <= DATA_LEFT;
            else                     left_ref[cnt_l[LOG2NT-1:0]] <= DATA_LEFT;
        end
    end

    for (genvar i = 0; i < NT; i++) begin : g_pack
        assign top_vec[i*BITS +: BITS] = top_ref[i];
    end

    planar_pred_4x4_row_calc #(
        .BITS (BITS)
    ) u_row_calc (
        .y      (y),
        .top    (top_vec),
        .left_y (left_ref[y]),
        .tr     (tr),
        .bl     (bl),
        .row    (row)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            PRED_ROW   <= '0;
            ROW_IDX    <= '0;
            PRED_VALID <= 1'b0;
            DONE       <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            if (!preset_flag && state == CALC) begin
                PRED_ROW   <= row;
                ROW_IDX    <= y;
                PRED_VALID <= 1'b1;
                DONE       <= (y == Y_LAST);
            end else begin
                PRED_VALID <= 1'b0;
                DONE       <= 1'b0;
            end
            if (preset_flag) BUSY <= 1'b1;
            else if (DONE)   BUSY <= 1'b0;
        end
    end
endmodule

// File: tb/tb_planar_pred_4x4.sv
// Drives the address-generator/RAM side of the predictor and checks every output beat
// against an arithmetic planar-prediction model.
module tb_planar_pred_4x4;
    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        preset_flag = 1'b0;
    logic        EN_TOP = 1'b0;
    logic        EN_LEFT = 1'b0;
    logic [7:0]  DATA_TOP = 8'd0;
    logic [7:0]  DATA_LEFT = 8'd0;
    logic [31:0] PRED_ROW;
    logic [1:0]  ROW_IDX;
    logic        PRED_VALID;
    logic        DONE;
    logic        BUSY;

    int errors = 0;
    int checks = 0;

    // t_val[0..3]=top, t_val[4]=tr, t_val[5]=surplus; l_val likewise with bl at [4].
    int          t_val [6];
    int          l_val [6];
    logic [31:0] rows_seen [4];

    planar_pred_4x4 dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .preset_flag (preset_flag),
        .EN_TOP      (EN_TOP),
        .EN_LEFT     (EN_LEFT),
        .DATA_TOP    (DATA_TOP),
        .DATA_LEFT   (DATA_LEFT),
        .PRED_ROW    (PRED_ROW),
        .ROW_IDX     (ROW_IDX),
        .PRED_VALID  (PRED_VALID),
        .DONE        (DONE),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] model_row(input int yy);
        logic [31:0] r;
        int s;
        r = '0;
        for (int x = 0; x < 4; x++) begin
            s = (3 - x) * l_val[yy] + (x + 1) * t_val[4] + (3 - yy) * t_val[x] + (yy + 1) * l_val[4] + 4;
            r[x*8 +: 8] = 8'(s / 8);
        end
        return r;
    endfunction

    task automatic randomize_refs();
        for (int i = 0; i < 6; i++) begin
            t_val[i] = int'($urandom_range(0, 255));
            l_val[i] = int'($urandom_range(0, 255));
        end
    endtask

    // Called at a negedge; preset is sampled at the next edge (edge 0). Observes edges 0..last_edge.
    // Enables start at edge 1, so bl lands at edge 6 and rows are expected at edges 7..10.
    task automatic run_block(input int nt, input int last_edge);
        int  e;
        bit  exp_valid;
        preset_flag = 1'b1;
        for (int s = 1; s <= last_edge + 1; s++) begin
            @(negedge CLK);
            e = s - 1;
            exp_valid = (e >= 7 && e <= 10);
            checks++;
            if (PRED_VALID !== exp_valid) begin
                errors++;
                $display("FAIL pred_valid edge %0d: got %b want %b", e, PRED_VALID, exp_valid);
            end
            checks++;
            if (DONE !== (e == 10)) begin
                errors++;
                $display("FAIL done edge %0d: got %b want %b", e, DONE, (e == 10));
            end
            checks++;
            if (BUSY !== (e <= 10)) begin
                errors++;
                $display("FAIL busy edge %0d: got %b want %b", e, BUSY, (e <= 10));
            end
            if (exp_valid) begin
                checks++;
                if (ROW_IDX !== 2'(e - 7)) begin
                    errors++;
                    $display("FAIL row_idx edge %0d: got %0d want %0d", e, ROW_IDX, e - 7);
                end
                checks++;
                if (PRED_ROW !== model_row(e - 7)) begin
                    errors++;
                    $display("FAIL pred_row y=%0d: got %h want %h", e - 7, PRED_ROW, model_row(e - 7));
                end
                rows_seen[e - 7] = PRED_ROW;
            end
            preset_flag = 1'b0;
            if (s <= last_edge) begin
                EN_TOP    = (s - 1 < nt);
                EN_LEFT   = (s - 1 < 5);
                DATA_TOP  = (s >= 2 && s - 2 < nt) ? 8'(t_val[s - 2]) : 8'($urandom);
                DATA_LEFT = (s >= 2 && s - 2 < 5) ? 8'(l_val[s - 2]) : 8'($urandom);
            end else begin
                EN_TOP  = 1'b0;
                EN_LEFT = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({PRED_ROW, ROW_IDX, PRED_VALID, DONE, BUSY} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%0d/%b/%b/%b want all zero", PRED_ROW, ROW_IDX, PRED_VALID, DONE, BUSY);
        end
        RST_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_uniform();
        for (int i = 0; i < 6; i++) begin
            t_val[i] = 100;
            l_val[i] = 100;
        end
        run_block(5, 11);
        for (int yy = 0; yy < 4; yy++) begin
            checks++;
            if (rows_seen[yy] !== 32'h64646464) begin
                errors++;
                $display("FAIL uniform_row%0d: got %h want 64646464", yy, rows_seen[yy]);
            end
        end
    endtask

    task automatic test_tr_only();
        for (int i = 0; i < 6; i++) begin
            t_val[i] = 0;
            l_val[i] = 0;
        end
        t_val[4] = 255;
        run_block(5, 11);
        for (int yy = 0; yy < 4; yy++) begin
            checks++;
            if (rows_seen[yy] !== 32'h80604020) begin
                errors++;
                $display("FAIL tr_only_row%0d: got %h want 80604020", yy, rows_seen[yy]);
            end
        end
    endtask

    task automatic test_mixed();
        t_val = '{10, 20, 30, 40, 90, 0};
        l_val = '{50, 60, 70, 80, 100, 0};
        run_block(5, 11);
        checks++;
        if (rows_seen[0][7:0] !== 8'd46) begin
            errors++;
            $display("FAIL mixed_row0_x0: got %0d want 46", rows_seen[0][7:0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            randomize_refs();
            run_block(5, 11);
        end
    endtask

    task automatic test_extra_top();
        randomize_refs();
        t_val[5] = t_val[4] ^ 8'hA5;
        run_block(6, 11);
    endtask

    task automatic test_abort();
        randomize_refs();
        run_block(5, 8);
        randomize_refs();
        run_block(5, 11);
    endtask

    task automatic test_back_to_back();
        randomize_refs();
        run_block(5, 10);
        randomize_refs();
        run_block(5, 11);
    endtask

    task automatic test_async_reset();
        randomize_refs();
        run_block(5, 3);
        #2;
        RST_n = 1'b0;
        #1;
        checks++;
        if ({PRED_ROW, ROW_IDX, PRED_VALID, DONE, BUSY} !== 37'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h/%0d/%b/%b/%b want all zero", PRED_ROW, ROW_IDX, PRED_VALID, DONE, BUSY);
        end
        @(negedge CLK);
        RST_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            EN_TOP    = 1'($urandom);
            EN_LEFT   = 1'($urandom);
            DATA_TOP  = 8'($urandom);
            DATA_LEFT = 8'($urandom);
            @(negedge CLK);
            checks++;
            if (PRED_VALID !== 1'b0 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle cycle %0d: got valid=%b busy=%b want 0/0", c, PRED_VALID, BUSY);
            end
        end
        EN_TOP  = 1'b0;
        EN_LEFT = 1'b0;
        randomize_refs();
        run_block(5, 11);
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_tr_only();
        test_mixed();
        test_random();
        test_extra_top();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
